// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared neuron datapath defaults, FSM encoding and activation helper
package nn_pkg;

  localparam int NN_DATA_W    = 8;
  localparam int NN_ENTRIES   = 4;
  localparam int NN_ACC_W     = 20;
  localparam int NN_FRAC_BITS = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_ACT  = 2'd2,
    ST_DONE = 2'd3
  } nn_state_e;

  localparam logic signed [NN_ACC_W-1:0] NN_ACT_MAX = NN_ACC_W'((1 << (NN_DATA_W - 1)) - 1);

  // Default-width shift/saturate/ReLU for activation stages built at package widths.
  function automatic logic [NN_DATA_W-1:0] sat_relu(input logic signed [NN_ACC_W-1:0] sum,
                                                     input int frac_bits);
    logic signed [NN_ACC_W-1:0] shifted;
    shifted = sum >>> frac_bits;
    if (shifted[NN_ACC_W-1])
      return '0;
    else if (shifted > NN_ACT_MAX)
      return NN_ACT_MAX[NN_DATA_W-1:0];
    else
      return shifted[NN_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/nn_sat_relu.sv
// rtl/nn_sat_relu.sv - combinational arithmetic shift, signed saturation and ReLU
module nn_sat_relu
  import nn_pkg::*;
#(
  parameter int DATA_W    = NN_DATA_W,
  parameter int ACC_W     = NN_ACC_W,
  parameter int FRAC_BITS = NN_FRAC_BITS
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic [DATA_W-1:0]       act
);

  localparam logic signed [ACC_W-1:0] ACT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);

  logic signed [ACC_W-1:0] shifted;

  // Any negative value clamps to zero, so the negative saturation limit never reaches the output.
  always_comb begin
    shifted = sum >>> FRAC_BITS;
    if (shifted[ACC_W-1])
      act = '0;
    else if (shifted > ACT_MAX)
      act = ACT_MAX[DATA_W-1:0];
    else
      act = shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/neuron_mac_unit.sv
// rtl/neuron_mac_unit.sv - per-neuron weight/input buffer with serial signed MAC and ReLU output
module neuron_mac_unit
  import nn_pkg::*;
#(
  parameter int UNIT_ID   = 0,
  parameter int DATA_W    = NN_DATA_W,
  parameter int ENTRIES   = NN_ENTRIES,
  parameter int ACC_W     = NN_ACC_W,
  parameter int FRAC_BITS = NN_FRAC_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                write,
  input  logic [1:0]          unit_sel,
  input  logic [1:0]          unit_address,
  input  logic [2*DATA_W-1:0] ram_data,
  input  logic                sum_trigger,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   act_out,
  output logic [ACC_W-1:0]    acc_out,
  output logic                busy,
  output logic                overrun
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  nn_state_e state, state_nxt;

  logic [2*DATA_W-1:0]       buffer [ENTRIES];
  logic [IDX_W-1:0]          idx;
  logic signed [ACC_W-1:0]   acc;
  logic                      trig_q, trig_qq, trig_edge;
  logic                      wr_hit, addr_ok;
  logic signed [DATA_W-1:0]  cur_w, cur_x;
  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]         act_nxt;

  // The trigger is registered before edge detection so the held second cycle is never a new edge.
  assign trig_edge = trig_q & ~trig_qq;
  assign wr_hit    = write && (unit_sel == UNIT_ID[1:0]);
  assign addr_ok   = int'(unit_address) < ENTRIES;
  assign cur_w     = buffer[idx][2*DATA_W-1:DATA_W];
  assign cur_x     = buffer[idx][DATA_W-1:0];
  assign prod      = cur_w * cur_x;

  nn_sat_relu #(
    .DATA_W    (DATA_W),
    .ACC_W     (ACC_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_sat_relu (
    .sum (acc),
    .act (act_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (trig_edge) state_nxt = ST_MAC;
      ST_MAC:  if (idx == IDX_W'(ENTRIES - 1)) state_nxt = ST_ACT;
      ST_ACT:  state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++)
        buffer[i] <= '0;
      idx     <= '0;
      acc     <= '0;
      trig_q  <= 1'b0;
      trig_qq <= 1'b0;
      act_out <= '0;
      acc_out <= '0;
      overrun <= 1'b0;
    end else begin
      trig_q  <= sum_trigger;
      trig_qq <= trig_q;

      if (state == ST_IDLE && wr_hit && addr_ok)
        buffer[unit_address] <= ram_data;

      if ((wr_hit || trig_edge) && state != ST_IDLE)
        overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (trig_edge) begin
            acc <= '0;
            idx <= '0;
          end
        end
        ST_MAC: begin
          acc <= acc + {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
          idx <= idx + 1'b1;
        end
        ST_ACT: begin
          act_out <= act_nxt;
          acc_out <= acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_unit.sv
// tb/tb_neuron_mac_unit.sv - scoreboard bench for neuron_mac_unit with directed vectors
module tb_neuron_mac_unit;

  localparam int ENTRIES = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [1:0]  unit_sel;
  logic [1:0]  unit_address;
  logic [15:0] ram_data;
  logic        sum_trigger;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  act_out;
  logic [19:0] acc_out;
  logic        busy;
  logic        overrun;

  typedef struct packed {
    logic [7:0]  act;
    logic [19:0] acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   trig_cyc = 0;
  bit   lat_pending = 1'b0;
  bit   prev_valid = 1'b0;
  bit   prev_hs = 1'b0;

  neuron_mac_unit dut (
    .clk          (clk),
    .reset        (reset),
    .write        (write),
    .unit_sel     (unit_sel),
    .unit_address (unit_address),
    .ram_data     (ram_data),
    .sum_trigger  (sum_trigger),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .act_out      (act_out),
    .acc_out      (acc_out),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  // Monitor: latency on the first valid cycle, scoreboard pop on each handshake, valid drop after it.
  always @(negedge clk) begin
    if (reset) begin
      prev_hs    = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_hs)
        check("valid_drop_after_transfer", {31'b0, out_valid}, 32'd0);
      if (out_valid && !prev_valid && lat_pending) begin
        check("latency", cyc - trig_cyc, ENTRIES + 2);
        lat_pending = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_result: got act %0d acc %0h, required no result", act_out, acc_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("act_out", {24'b0, act_out}, {24'b0, mon_e.act});
          check("acc_out", {12'b0, acc_out}, {12'b0, mon_e.acc});
        end
      end
      prev_hs    = out_valid && out_ready;
      prev_valid = out_valid;
    end
  end

  task automatic write_entry(input logic [1:0] sel, input logic [1:0] addr, input int w, input int x);
    unit_sel     = sel;
    unit_address = addr;
    ram_data     = {8'(w), 8'(x)};
    write        = 1'b1;
    @(posedge clk); #1;
    write        = 1'b0;
  endtask

  task automatic load(input int w0, input int x0, input int w1, input int x1,
                      input int w2, input int x2, input int w3, input int x3);
    write_entry(2'd0, 2'd0, w0, x0);
    write_entry(2'd0, 2'd1, w1, x1);
    write_entry(2'd0, 2'd2, w2, x2);
    write_entry(2'd0, 2'd3, w3, x3);
  endtask

  task automatic pulse_trigger();
    sum_trigger = 1'b1;
    @(posedge clk); #1;
    trig_cyc    = cyc;
    lat_pending = 1'b1;
    @(posedge clk); #1;
    sum_trigger = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_timeout: %0d results outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_case(input string name, input logic [7:0] ea, input logic [19:0] ec);
    exp_q.push_back({ea, ec});
    pulse_trigger();
    wait_drain(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; write = 1'b0; unit_sel = 2'd0; unit_address = 2'd0;
    ram_data = '0; sum_trigger = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_act_out", {24'b0, act_out}, 32'd0);
    check("reset_acc_out", {12'b0, acc_out}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_overrun", {31'b0, overrun}, 32'd0);
    @(posedge clk); #1;

    // 1*10 + 2*20 + 1*5 + (-1)*4 = 51
    load(1, 10, 2, 20, 1, 5, -1, 4);
    run_case("basic", 8'd51, 20'd51);
    check("no_spurious_overrun", {31'b0, overrun}, 32'd0);

    load(4, 10, 4, 20, 4, 30, 4, 40);
    run_case("saturate", 8'd127, 20'd400);

    load(-1, 5, -1, 5, -1, 5, -1, 5);
    run_case("relu_negative", 8'd0, 20'hFFFEC);

    load(-128, -128, -128, -128, -128, -128, -128, -128);
    run_case("relu_large", 8'd127, 20'd65536);

    // Writes aimed at unit 1 must leave this buffer at the -128 vectors.
    for (int a = 0; a < ENTRIES; a++)
      write_entry(2'd1, 2'(a), 7, 9);
    run_case("unit_filter", 8'd127, 20'd65536);

    out_ready = 1'b0;
    exp_q.push_back({8'd127, 20'd65536});
    pulse_trigger();
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (10) begin
      @(negedge clk);
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
      check("stall_act_out", {24'b0, act_out}, 32'd127);
      check("stall_acc_out", {12'b0, acc_out}, 32'd65536);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("backpressure");

    // 1 + 4 + 9 + 16 = 30; a write and a fresh trigger edge land during MAC.
    load(1, 1, 2, 2, 3, 3, 4, 4);
    exp_q.push_back({8'd30, 20'd30});
    pulse_trigger();
    unit_sel = 2'd0; unit_address = 2'd0; ram_data = {8'd100, 8'd100};
    write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
    sum_trigger = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    sum_trigger = 1'b0;
    wait_drain("overrun_case");
    check("overrun_set", {31'b0, overrun}, 32'd1);

    pulse_trigger();
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    lat_pending = 1'b0;
    @(negedge clk);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_act_out", {24'b0, act_out}, 32'd0);
    check("abort_acc_out", {12'b0, acc_out}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_overrun", {31'b0, overrun}, 32'd0);
    @(posedge clk); #1;
    run_case("after_reset", 8'd0, 20'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
